// File: rtl/access_lockout_ctrl_pkg.sv
// Shared state encoding and sizing constants for the access lockout controller.
package access_lockout_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COOLDOWN = 2'd1,
      ST_OPEN     = 2'd2,
      ST_LOCKOUT  = 2'd3
   } state_t;

   localparam int DEF_TICK_DIV = 50000000;
   localparam int SECS_W       = 6;

endpackage

// File: rtl/access_lockout_ctrl_tick_gen.sv
// Clock divider: single-cycle tick every TICK_DIV cycles, combinational off the count.
// Restart holds the count at zero, so the first tick lands TICK_DIV cycles after restart drops.
module access_lockout_ctrl_tick_gen
   import access_lockout_ctrl_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_restart,
   output logic o_tick
);

   localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign o_tick = w_last && !i_restart;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_restart) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/access_lockout_ctrl.sv
// Turns checker pass/wrong/timeout edges into a timed door-open window, fail counter and lockout.
// Flag edges are acted on 3 cycles after the input rises; all outputs are registered.
module access_lockout_ctrl
   import access_lockout_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int OPEN_SECS = 5,
   parameter int LOCK_SECS = 30,
   parameter int MAX_FAILS = 3
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic              i_curr_pass,
   input  logic              i_wrong_pass,
   input  logic              i_time_out,
   input  logic              i_ack_button,
   output logic              o_validation_enable,
   output logic              o_door_open,
   output logic              o_locked,
   output logic              o_alarm,
   output logic [1:0]        o_fail_count,
   output logic [SECS_W-1:0] o_seconds_left
);

   localparam logic [SECS_W-1:0] OPEN_N  = SECS_W'(OPEN_SECS);
   localparam logic [SECS_W-1:0] LOCK_N  = SECS_W'(LOCK_SECS);
   localparam logic [SECS_W-1:0] ONE_SEC = SECS_W'(1);
   localparam logic [1:0]        MAX_FC  = 2'(MAX_FAILS);
   localparam logic [2:0]        MAX_FC3 = 3'(MAX_FAILS);

   state_t            r_state;
   logic              r_ve;
   logic              r_door;
   logic              r_locked;
   logic              r_alarm;
   logic [1:0]        r_fail_count;
   logic [SECS_W-1:0] r_secs;

   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] r_prev;
   logic [1:0] r_settle;

   logic [3:0] w_raw;
   logic [3:0] w_rise;
   logic       w_pass_ev;
   logic       w_fail_ev;
   logic       w_ack_ev;
   logic [2:0] w_fc_inc;
   logic       w_tick;

   assign w_raw     = {i_ack_button, i_time_out, i_wrong_pass, i_curr_pass};
   assign w_rise    = r_sync2 & ~r_prev;
   assign w_pass_ev = w_rise[0];
   assign w_fail_ev = w_rise[1] | w_rise[2];
   assign w_ack_ev  = w_rise[3];
   assign w_fc_inc  = {1'b0, r_fail_count} + 3'd1;

   // r_prev is held high until the synchronizer carries real samples, so a flag
   // that was already high across reset never looks like a fresh rising edge.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_prev   <= '1;
         r_settle <= '0;
      end else begin
         r_sync1  <= w_raw;
         r_sync2  <= r_sync1;
         r_prev   <= r_sync2 | {4{~r_settle[1]}};
         r_settle <= {r_settle[0], 1'b1};
      end
   end

   access_lockout_ctrl_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_restart (r_state == ST_IDLE),
      .o_tick    (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= ST_IDLE;
         r_ve         <= 1'b0;
         r_door       <= 1'b0;
         r_locked     <= 1'b0;
         r_alarm      <= 1'b0;
         r_fail_count <= '0;
         r_secs       <= '0;
      end else begin
         r_ve <= i_enable && (r_state == ST_IDLE);
         if (w_ack_ev) begin
            r_alarm <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (i_enable && w_pass_ev) begin
                  r_state      <= ST_OPEN;
                  r_door       <= 1'b1;
                  r_fail_count <= '0;
                  r_secs       <= OPEN_N;
               end else if (i_enable && w_fail_ev) begin
                  if (w_fc_inc >= MAX_FC3) begin
                     r_state      <= ST_LOCKOUT;
                     r_locked     <= 1'b1;
                     r_alarm      <= 1'b1;
                     r_fail_count <= MAX_FC;
                     r_secs       <= LOCK_N;
                  end else begin
                     r_state      <= ST_COOLDOWN;
                     r_fail_count <= w_fc_inc[1:0];
                  end
               end
            end
            ST_COOLDOWN: begin
               if (w_tick) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_OPEN: begin
               if (!i_enable || (w_tick && r_secs == ONE_SEC)) begin
                  r_state <= ST_IDLE;
                  r_door  <= 1'b0;
                  r_secs  <= '0;
               end else if (w_tick) begin
                  r_secs <= r_secs - 1'b1;
               end
            end
            ST_LOCKOUT: begin
               // Enable and checker events are deliberately ignored until expiry.
               if (w_tick && r_secs == ONE_SEC) begin
                  r_state      <= ST_COOLDOWN;
                  r_locked     <= 1'b0;
                  r_alarm      <= 1'b0;
                  r_fail_count <= '0;
                  r_secs       <= '0;
               end else if (w_tick) begin
                  r_secs <= r_secs - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_validation_enable = r_ve;
   assign o_door_open         = r_door;
   assign o_locked            = r_locked;
   assign o_alarm             = r_alarm;
   assign o_fail_count        = r_fail_count;
   assign o_seconds_left      = r_secs;

endmodule

// File: tb/tb_access_lockout_ctrl.sv
// Bench for access_lockout_ctrl: directed vector table plus randomized run against a timing model.
module tb_access_lockout_ctrl;

   localparam int TD = 10;
   localparam int OS = 3;
   localparam int LS = 4;
   localparam int MF = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, en = 1'b0, cp = 1'b0, wp = 1'b0, to = 1'b0, ack = 1'b0;
   logic       ve, door, locked, alarm;
   logic [1:0] fc;
   logic [5:0] secs;

   always #5 clk = ~clk;

   access_lockout_ctrl #(
      .TICK_DIV  (TD),
      .OPEN_SECS (OS),
      .LOCK_SECS (LS),
      .MAX_FAILS (MF)
   ) dut (
      .i_clk               (clk),
      .i_reset_n           (rst_n),
      .i_enable            (en),
      .i_curr_pass         (cp),
      .i_wrong_pass        (wp),
      .i_time_out          (to),
      .i_ack_button        (ack),
      .o_validation_enable (ve),
      .o_door_open         (door),
      .o_locked            (locked),
      .o_alarm             (alarm),
      .o_fail_count        (fc),
      .o_seconds_left      (secs)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: mode 0 idle, 1 cooldown, 2 open, 3 lockout. Windows are
   // timed by edge-count arithmetic from the entry edge rather than a counter.
   int       m_mode = 0, m_entry = 0, m_fc = 0, m_edge = 0, m_rst_edge = -100;
   bit       m_alarm = 0, m_ve = 0, m_seen_rst = 0;
   logic [3:0] h1 = '0, h2 = '0, h3 = '0;

   task automatic model_step();
      logic [3:0] ev;
      int el;
      m_edge++;
      // An edge is acted on when sampled high two edges ago and low three edges
      // ago, and only if both samples were taken after the last reset.
      ev = h2 & ~h3;
      if (m_edge - 3 < m_rst_edge + 1) ev = '0;
      h3 = h2;
      h2 = h1;
      h1 = {ack, to, wp, cp};
      if (!rst_n) begin
         m_mode = 0; m_fc = 0; m_alarm = 0; m_ve = 0;
         m_rst_edge = m_edge; m_seen_rst = 1;
      end else begin
         el   = m_edge - m_entry;
         m_ve = en && (m_mode == 0);
         if (ev[3]) m_alarm = 0;
         case (m_mode)
            0: begin
               if (en && ev[0]) begin
                  m_mode = 2; m_entry = m_edge; m_fc = 0;
               end else if (en && (ev[1] || ev[2])) begin
                  m_entry = m_edge;
                  if (m_fc + 1 >= MF) begin
                     m_mode = 3; m_fc = MF; m_alarm = 1;
                  end else begin
                     m_mode = 1; m_fc = m_fc + 1;
                  end
               end
            end
            1: if (el == TD) m_mode = 0;
            2: if (!en || el == OS * TD) m_mode = 0;
            default: if (el == LS * TD) begin
               m_mode = 1; m_entry = m_edge; m_fc = 0; m_alarm = 0;
            end
         endcase
      end
   endtask

   function automatic logic [11:0] model_out();
      int s;
      s = 0;
      if (m_mode == 2) s = OS - (m_edge - m_entry) / TD;
      if (m_mode == 3) s = LS - (m_edge - m_entry) / TD;
      return {m_ve, (m_mode == 2), (m_mode == 3), m_alarm, 2'(m_fc), 6'(s)};
   endfunction

   function automatic logic [11:0] dut_out();
      return {ve, door, locked, alarm, fc, secs};
   endfunction

   task automatic cycle();
      logic [11:0] exp;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_seen_rst) begin
         exp = model_out();
         n_checks++;
         if (dut_out() === exp) n_pass++;
         else $display("FAIL model edge %0d: got ve/door/lock/alarm/fc/secs=%b expected %b",
                       m_edge, dut_out(), exp);
      end
   endtask

   typedef struct {
      int          cyc;
      logic [5:0]  in;   // {rst_n, en, cp, wp, to, ack}
      logic [11:0] exp;  // {ve, door, locked, alarm, fc[1:0], secs[5:0]}
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int cyc, logic [5:0] in, logic [3:0] fl, int f, int s);
      vec_t v;
      v.cyc = cyc;
      v.in  = in;
      v.exp = {fl, 2'(f), 6'(s)};
      return v;
   endfunction

   initial begin
      // Reset, then one pass: door window of 3 ticks, 10 cycles each.
      tbl.push_back(mk( 2, 6'b000000, 4'b0000, 0, 0));
      tbl.push_back(mk( 4, 6'b110000, 4'b1000, 0, 0));
      tbl.push_back(mk( 2, 6'b111000, 4'b1000, 0, 0));
      tbl.push_back(mk( 1, 6'b111000, 4'b1100, 0, 3));
      tbl.push_back(mk( 1, 6'b111000, 4'b0100, 0, 3));
      tbl.push_back(mk( 8, 6'b111000, 4'b0100, 0, 3));
      tbl.push_back(mk( 1, 6'b111000, 4'b0100, 0, 2));
      tbl.push_back(mk(10, 6'b111000, 4'b0100, 0, 1));
      tbl.push_back(mk( 9, 6'b111000, 4'b0100, 0, 1));
      tbl.push_back(mk( 1, 6'b111000, 4'b0000, 0, 0));
      tbl.push_back(mk( 1, 6'b111000, 4'b1000, 0, 0));
      tbl.push_back(mk( 3, 6'b110000, 4'b1000, 0, 0));
      // Two wrong attempts, each followed by a one-tick cooldown.
      tbl.push_back(mk( 3, 6'b110100, 4'b1000, 1, 0));
      tbl.push_back(mk( 1, 6'b110000, 4'b0000, 1, 0));
      tbl.push_back(mk( 9, 6'b110000, 4'b0000, 1, 0));
      tbl.push_back(mk( 1, 6'b110000, 4'b1000, 1, 0));
      tbl.push_back(mk( 3, 6'b110100, 4'b1000, 2, 0));
      tbl.push_back(mk(11, 6'b110000, 4'b1000, 2, 0));
      // Third fail by timeout -> lockout; ack and Enable=0 during lockout.
      tbl.push_back(mk( 3, 6'b110010, 4'b1011, 3, 4));
      tbl.push_back(mk( 1, 6'b110000, 4'b0011, 3, 4));
      tbl.push_back(mk( 3, 6'b100001, 4'b0010, 3, 4));
      tbl.push_back(mk( 5, 6'b100000, 4'b0010, 3, 4));
      tbl.push_back(mk( 1, 6'b110000, 4'b0010, 3, 3));
      tbl.push_back(mk(29, 6'b110000, 4'b0010, 3, 1));
      tbl.push_back(mk( 1, 6'b110000, 4'b0000, 0, 0));
      tbl.push_back(mk(10, 6'b110000, 4'b0000, 0, 0));
      tbl.push_back(mk( 1, 6'b110000, 4'b1000, 0, 0));
      // Pass and wrong together -> open; Enable drop aborts the window.
      tbl.push_back(mk( 3, 6'b111100, 4'b1100, 0, 3));
      tbl.push_back(mk( 5, 6'b110000, 4'b0100, 0, 3));
      tbl.push_back(mk( 1, 6'b100000, 4'b0000, 0, 0));
      tbl.push_back(mk( 4, 6'b110000, 4'b1000, 0, 0));
      // Reset mid-window; a pass flag held across reset must not reopen.
      tbl.push_back(mk( 3, 6'b111000, 4'b1100, 0, 3));
      tbl.push_back(mk(10, 6'b111000, 4'b0100, 0, 2));
      tbl.push_back(mk( 1, 6'b011000, 4'b0000, 0, 0));
      tbl.push_back(mk(10, 6'b111000, 4'b1000, 0, 0));
      tbl.push_back(mk( 3, 6'b110000, 4'b1000, 0, 0));

      foreach (tbl[k]) begin
         {rst_n, en, cp, wp, to, ack} = tbl[k].in;
         repeat (tbl[k].cyc) cycle();
         n_checks++;
         if (dut_out() === tbl[k].exp) n_pass++;
         else $display("FAIL vector %0d: got ve/door/lock/alarm/fc/secs=%b expected %b",
                       k, dut_out(), tbl[k].exp);
      end

      // Randomized traffic, checked each cycle against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) cp = ~cp;
         if ($urandom_range(0, 14) == 0) wp = ~wp;
         if ($urandom_range(0, 24) == 0) to = ~to;
         if ($urandom_range(0, 59) == 0) ack = ~ack;
         if (en) begin
            if ($urandom_range(0, 149) == 0) en = 1'b0;
         end else begin
            if ($urandom_range(0, 9) == 0) en = 1'b1;
         end
         rst_n = ($urandom_range(0, 799) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
